apb_timer_regs_mc: RTL

APB_TIMER_REGS_MC -- requirements
Module: apb_timer_regs_mc

---
 rtl/apb_timer_regs_mc.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/apb_timer_regs_mc.sv
// APB3 register block for a multi-channel timer: per-channel TDR/TCR/TSR/TIER
// behind a wait-state access FSM. Interrupt logic is built only when TIMER_IRQ_EN is defined.
module apb_timer_regs_mc #(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                          pclk,
    input  logic                          preset,
    input  logic                          psel,
    input  logic                          penable,
    input  logic                          pwrite,
    input  logic [7:0]                    paddr,
    input  logic [31:0]                   pwdata,
    output logic [31:0]                   prdata,
    output logic                          pready,
    output logic                          pslverr,
    input  logic [NUM_CH-1:0]             ovf_trig,
    input  logic [NUM_CH-1:0]             udf_trig,
    output logic [NUM_CH-1:0]             en,
    output logic [NUM_CH-1:0]             updown,
    output logic [NUM_CH-1:0]             load,
    output logic [2*NUM_CH-1:0]           cks,
    output logic [NUM_CH*CNT_WIDTH-1:0]   tdr,
    output logic [2*NUM_CH-1:0]           clr_trig,
    output logic [NUM_CH-1:0]             irq
);

    localparam int unsigned WCW = 3;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t           state, state_nxt;
    logic [WCW-1:0]   wcnt, wcnt_nxt;
    logic [1:0]       ch, off;
    logic             valid, done, wr_done;
    logic [2*NUM_CH-1:0] tsr;
    logic [2*NUM_CH-1:0] tier;
    logic             unused_wdata;

    assign ch           = paddr[5:4];
    assign off          = paddr[3:2];
    assign valid        = (32'(ch) < NUM_CH) && (paddr[1:0] == 2'd0) && (paddr[7:6] == 2'd0);
    assign done         = psel && penable && pready;
    assign wr_done      = done && pwrite && valid;
    assign pslverr      = done && !valid;
    assign unused_wdata = ^pwdata;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Access phase: SETUP is a fixed extra cycle, then WAIT_CYCLES wait states in ACCESS.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        pready    = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) state_nxt = SETUP;
            end
            SETUP: begin
                wcnt_nxt  = '0;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                pready   = (wcnt == WCW'(WAIT_CYCLES));
                wcnt_nxt = wcnt + WCW'(1);
                if (!psel || (penable && pready)) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Per-channel control/data registers; status set beats a same-cycle clear.
    always_ff @(posedge pclk) begin
        if (preset) begin
            tdr    <= '0;
            en     <= '0;
            updown <= '0;
            cks    <= '0;
            load   <= '0;
            tsr    <= '0;
        end else begin
            load <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_done && ch == 2'(c)) begin
                    case (off)
                        2'd0: tdr[c*CNT_WIDTH +: CNT_WIDTH] <= pwdata[CNT_WIDTH-1:0];
                        2'd1: begin
                            updown[c]      <= pwdata[5];
                            en[c]          <= pwdata[4];
                            cks[2*c +: 2]  <= pwdata[1:0];
                            load[c]        <= pwdata[7];
                        end
                        default: ;
                    endcase
                end
                tsr[2*c +: 2] <= (tsr[2*c +: 2] & ~clr_trig[2*c +: 2]) | {udf_trig[c], ovf_trig[c]};
            end
        end
    end

    always_comb begin
        clr_trig = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_done && ch == 2'(c) && off == 2'd2) clr_trig[2*c +: 2] = pwdata[1:0];
        end
    end

`ifdef TIMER_IRQ_EN
    always_ff @(posedge pclk) begin
        if (preset) begin
            tier <= '0;
            irq  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_done && ch == 2'(c) && off == 2'd3) tier[2*c +: 2] <= pwdata[1:0];
                irq[c] <= |(tsr[2*c +: 2] & tier[2*c +: 2]);
            end
        end
    end
`else
    assign tier = '0;
    assign irq  = '0;
`endif

    // Read data is driven only while a valid read is completing.
    always_comb begin
        prdata = '0;
        if (done && !pwrite && valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch == 2'(c)) begin
                    case (off)
                        2'd0:    prdata = 32'(tdr[c*CNT_WIDTH +: CNT_WIDTH]);
                        2'd1:    prdata = 32'({updown[c], en[c], 2'b00, cks[2*c +: 2]});
                        2'd2:    prdata = 32'(tsr[2*c +: 2]);
                        default: prdata = 32'(tier[2*c +: 2]);
                    endcase
                end
            end
        end
    end

endmodule
